// File: rtl/axi_ad9364_pattern_pkg.sv
// ---------------------------------------------------------------------------
// axi_ad9364_pattern_pkg
//
// Shared definitions for the AD9364 DAC test-pattern generator:
//   - pattern mode encodings driven on cfg_mode
//   - generator FSM state encodings
//   - PRBS16 tap mask, default seed and default alternating patterns
//   - latched configuration record and small helper functions
// ---------------------------------------------------------------------------
package axi_ad9364_pattern_pkg;

    // Pattern modes (cfg_mode)
    localparam logic [1:0] MODE_ALT  = 2'd0;
    localparam logic [1:0] MODE_RAMP = 2'd1;
    localparam logic [1:0] MODE_PRBS = 2'd2;
    localparam logic [1:0] MODE_ZERO = 2'd3;

    // Generator FSM states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    // Fibonacci PRBS16 taps: bits 15, 13, 12, 10
    localparam logic [15:0] LFSR_TAPS     = 16'hB400;
    localparam logic [15:0] DEF_LFSR_SEED = 16'hACE1;

    // Default alternating-mode patterns (low DATA_WIDTH bits are used)
    localparam logic [15:0] DEF_PAT_A_I = 16'h0434;
    localparam logic [15:0] DEF_PAT_A_Q = 16'h03EB;
    localparam logic [15:0] DEF_PAT_B_I = 16'h0902;
    localparam logic [15:0] DEF_PAT_B_Q = 16'h02DF;

    // Configuration captured when a run starts
    typedef struct packed {
        logic [1:0]  mode;
        logic        r1_mode;
        logic [3:0]  div;
        logic [15:0] burst_len;
    } pat_cfg_t;

    // One shift-left step of the PRBS16; the feedback enters at bit 0
    function automatic logic [15:0] lfsr16_next(input logic [15:0] l);
        return {l[14:0], ^(l & LFSR_TAPS)};
    endfunction

    // Clocks per valid; a divider of 0 behaves as 1
    function automatic logic [3:0] eff_div(input logic [3:0] div);
        return (div == 4'd0) ? 4'd1 : div;
    endfunction

endpackage

// File: rtl/axi_ad9364_lfsr16.sv
// ---------------------------------------------------------------------------
// axi_ad9364_lfsr16
//
// 16-bit Fibonacci PRBS register used by the pattern generator.
//   clk      : rising-edge clock
//   rstn     : asynchronous active-low reset, reloads SEED
//   load     : reload SEED (has priority over advance)
//   advance  : step the sequence by one shift
//   value    : current register contents
// ---------------------------------------------------------------------------
module axi_ad9364_lfsr16
    import axi_ad9364_pattern_pkg::*;
#(
    parameter logic [15:0] SEED = DEF_LFSR_SEED
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        load,
    input  logic        advance,
    output logic [15:0] value
);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            value <= SEED;
        end else if (load) begin
            value <= SEED;
        end else if (advance) begin
            value <= lfsr16_next(value);
        end
    end

endmodule

// File: rtl/axi_ad9364_pattern_gen.sv
// ---------------------------------------------------------------------------
// axi_ad9364_pattern_gen
//
// DAC test-pattern source feeding the AD9364 digital interface.
//   clk, rstn          : clock / asynchronous active-low reset
//   cfg_enable         : level run request; a run starts when it is sampled
//                        high in IDLE, and re-arming needs a low phase
//   cfg_mode           : 0 alternating, 1 ramp, 2 PRBS16, 3 zero
//   cfg_r1_mode        : 1 = single channel (channel 2 driven to 0)
//   cfg_valid_div      : clocks per valid (0 behaves as 1)
//   cfg_burst_len      : valids per burst, 0 = continuous
//   dac_valid          : sample strobe
//   dac_data_i1/q1     : channel-1 samples
//   dac_data_i2/q2     : channel-2 samples (inverse of channel 1, or 0)
//   dac_r1_mode        : registered copy of the latched r1 mode
//   running            : generator in RUN
//   done               : one-cycle pulse the cycle after the final valid
//   sample_cnt         : valids issued since the last start (wraps)
// All cfg_* inputs are captured on the starting edge and ignored afterwards.
// ---------------------------------------------------------------------------
module axi_ad9364_pattern_gen
    import axi_ad9364_pattern_pkg::*;
#(
    parameter int          DATA_WIDTH = 12,
    parameter logic [15:0] PAT_A_I    = DEF_PAT_A_I,
    parameter logic [15:0] PAT_A_Q    = DEF_PAT_A_Q,
    parameter logic [15:0] PAT_B_I    = DEF_PAT_B_I,
    parameter logic [15:0] PAT_B_Q    = DEF_PAT_B_Q,
    parameter logic [15:0] LFSR_SEED  = DEF_LFSR_SEED
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  cfg_enable,
    input  logic [1:0]            cfg_mode,
    input  logic                  cfg_r1_mode,
    input  logic [3:0]            cfg_valid_div,
    input  logic [15:0]           cfg_burst_len,
    output logic                  dac_valid,
    output logic [DATA_WIDTH-1:0] dac_data_i1,
    output logic [DATA_WIDTH-1:0] dac_data_q1,
    output logic [DATA_WIDTH-1:0] dac_data_i2,
    output logic [DATA_WIDTH-1:0] dac_data_q2,
    output logic                  dac_r1_mode,
    output logic                  running,
    output logic                  done,
    output logic [31:0]           sample_cnt
);

    logic [1:0]            state;
    pat_cfg_t              cfg_q;
    logic [3:0]            div_cnt;
    logic [15:0]           burst_cnt;
    logic [DATA_WIDTH-1:0] ramp;
    logic                  phase;        // 0 = pattern A, 1 = pattern B
    logic                  burst_end_q;  // final valid issued last edge

    logic                  start;
    logic                  fire;
    logic                  last;
    logic [15:0]           lfsr_value;

    logic [DATA_WIDTH-1:0] pat_i1;
    logic [DATA_WIDTH-1:0] pat_q1;
    logic [DATA_WIDTH-1:0] pat_i2;
    logic [DATA_WIDTH-1:0] pat_q2;

    // -----------------------------------------------------------------------
    // Control decode
    // -----------------------------------------------------------------------
    always_comb begin
        start = (state == ST_IDLE) && cfg_enable;
        // A dropped enable suppresses the valid on the same edge, so the
        // strobe never appears after the stop request is seen.
        fire  = (state == ST_RUN) && cfg_enable && (div_cnt == 4'd0);
        last  = fire && (cfg_q.burst_len != 16'd0)
                     && (burst_cnt == cfg_q.burst_len - 16'd1);
    end

    axi_ad9364_lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk     (clk),
        .rstn    (rstn),
        .load    (start),
        .advance (fire),
        .value   (lfsr_value)
    );

    // -----------------------------------------------------------------------
    // Pattern selection for the valid about to be issued
    // -----------------------------------------------------------------------
    always_comb begin
        pat_i1 = '0;
        pat_q1 = '0;
        case (cfg_q.mode)
            MODE_ALT: begin
                pat_i1 = phase ? PAT_B_I[DATA_WIDTH-1:0] : PAT_A_I[DATA_WIDTH-1:0];
                pat_q1 = phase ? PAT_B_Q[DATA_WIDTH-1:0] : PAT_A_Q[DATA_WIDTH-1:0];
            end
            MODE_RAMP: begin
                pat_i1 = ramp;
                pat_q1 = ~ramp;
            end
            MODE_PRBS: begin
                pat_i1 = lfsr_value[DATA_WIDTH-1:0];
                pat_q1 = lfsr_value[15:16-DATA_WIDTH];
            end
            default: begin
                pat_i1 = '0;
                pat_q1 = '0;
            end
        endcase

        if (cfg_q.r1_mode) begin
            pat_i2 = '0;
            pat_q2 = '0;
        end else begin
            pat_i2 = ~pat_i1;
            pat_q2 = ~pat_q1;
        end
    end

    // -----------------------------------------------------------------------
    // FSM, cadence, counters and output registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= ST_IDLE;
            cfg_q       <= '0;
            div_cnt     <= '0;
            burst_cnt   <= '0;
            ramp        <= '0;
            phase       <= 1'b0;
            burst_end_q <= 1'b0;
            dac_valid   <= 1'b0;
            dac_data_i1 <= '0;
            dac_data_q1 <= '0;
            dac_data_i2 <= '0;
            dac_data_q2 <= '0;
            dac_r1_mode <= 1'b0;
            running     <= 1'b0;
            done        <= 1'b0;
            sample_cnt  <= '0;
        end else begin
            dac_valid   <= fire;
            dac_r1_mode <= cfg_q.r1_mode;
            // done trails the final valid by one cycle, independent of the
            // state, so an enable drop alongside the final valid keeps it.
            burst_end_q <= last;
            done        <= burst_end_q;

            case (state)
                ST_IDLE: begin
                    if (cfg_enable) begin
                        cfg_q.mode      <= cfg_mode;
                        cfg_q.r1_mode   <= cfg_r1_mode;
                        cfg_q.div       <= cfg_valid_div;
                        cfg_q.burst_len <= cfg_burst_len;
                        div_cnt         <= '0;
                        burst_cnt       <= '0;
                        ramp            <= '0;
                        phase           <= 1'b0;
                        sample_cnt      <= '0;
                        running         <= 1'b1;
                        state           <= ST_RUN;
                    end
                end

                ST_RUN: begin
                    if (!cfg_enable) begin
                        running <= 1'b0;
                        state   <= ST_IDLE;
                    end else if (fire) begin
                        dac_data_i1 <= pat_i1;
                        dac_data_q1 <= pat_q1;
                        dac_data_i2 <= pat_i2;
                        dac_data_q2 <= pat_q2;
                        sample_cnt  <= sample_cnt + 32'd1;
                        burst_cnt   <= burst_cnt + 16'd1;
                        ramp        <= ramp + DATA_WIDTH'(1);
                        phase       <= ~phase;
                        div_cnt     <= eff_div(cfg_q.div) - 4'd1;
                        if (last) begin
                            running <= 1'b0;
                            state   <= ST_HOLD;
                        end
                    end else begin
                        div_cnt <= div_cnt - 4'd1;
                    end
                end

                ST_HOLD: begin
                    if (!cfg_enable) begin
                        state <= ST_IDLE;
                    end
                end

                default: begin
                    running <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
